// File: rtl/uart_msg_streamer_if.sv
// Byte stream handshake between the message streamer and the UART TX serialiser.
// A byte moves on any rising edge where tx_valid and tx_ready are both high.
interface uart_msg_streamer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_msg_streamer.sv
// Writable message buffer streamed byte by byte into a UART transmitter.
// Supports one-shot and repeat (beacon) modes, and abort at a byte boundary.
module uart_msg_streamer #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 16,
    parameter int                ADDR_W    = 4,
    parameter logic [DATA_W-1:0] INIT_BYTE = DATA_W'(139)
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W:0]     msg_len,
    input  logic                repeat_mode,
    input  logic                start,
    input  logic                abort,
    uart_msg_streamer_if.master tx,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [ADDR_W-1:0]   cur_idx
);
    localparam int              LEN_W   = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

    state_t            r_state;
    logic [ADDR_W:0]   r_len;
    logic              r_rep;
    logic              r_abort_pend;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_aborted;

    // Entries are stored XOR INIT_BYTE so that zero-initialised storage reads back
    // as INIT_BYTE without needing any reset or preload of the array.
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [DATA_W-1:0] w_rd_data;
    logic [ADDR_W:0]   w_len_clamped;
    logic              w_last;
    logic              w_xfer;
    logic              w_abort;

    assign w_rd_data     = r_mem[r_idx] ^ INIT_BYTE;
    assign w_len_clamped = (msg_len > DEPTH_L) ? DEPTH_L : msg_len;
    assign w_last        = ({1'b0, r_idx} == (r_len - LEN_W'(1)));
    assign w_xfer        = r_tx_valid && tx.tx_ready;
    assign w_abort       = r_abort_pend || abort;

    always_ff @(posedge CLOCK) begin
        if (wr_en && (r_state == S_IDLE)) begin
            r_mem[wr_addr] <= wr_data ^ INIT_BYTE;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_rep        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_idx        <= '0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (msg_len == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_len        <= w_len_clamped;
                            r_rep        <= repeat_mode;
                            r_idx        <= '0;
                            r_aborted    <= 1'b0;
                            r_abort_pend <= 1'b0;
                            r_busy       <= 1'b1;
                            r_state      <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    r_tx_data  <= w_rd_data;
                    r_tx_valid <= 1'b1;
                    r_state    <= S_SEND;
                    if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        // Abort raised in the transfer cycle itself still ends the message here.
                        r_tx_valid   <= 1'b0;
                        r_abort_pend <= 1'b0;
                        if (w_abort) begin
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_aborted <= 1'b1;
                        end else if (w_last && r_rep) begin
                            r_idx   <= '0;
                            r_state <= S_FETCH;
                        end else if (w_last) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + ADDR_W'(1);
                            r_state <= S_FETCH;
                        end
                    end else if (abort) begin
                        r_abort_pend <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx.tx_data  = r_tx_data;
    assign tx.tx_valid = r_tx_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign cur_idx     = r_idx;
endmodule

// File: tb/tb_uart_msg_streamer.sv
// Randomised bench for uart_msg_streamer: observed byte stream and status pulses
// are compared against a buffer/stream model built from the block's rules.
module tb_uart_msg_streamer;
    logic       CLOCK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [4:0] msg_len;
    logic       repeat_mode;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] cur_idx;

    uart_msg_streamer_if #(.DATA_W(8)) tx_if ();

    uart_msg_streamer #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .INIT_BYTE(8'd139)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .repeat_mode(repeat_mode), .start(start), .abort(abort),
        .tx(tx_if.master),
        .busy(busy), .done(done), .aborted(aborted), .cur_idx(cur_idx)
    );

    always #5 CLOCK = ~CLOCK;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] exp_q [$];
    logic [7:0] obs [$];
    int done_cnt, valid_cnt, stab_err, cyc, last_xfer_cyc, done_cyc;
    logic busy_at_done;
    logic prev_hold;
    logic [7:0] prev_data;
    int ready_mode = 0;

    // Monitor: looks at the bus mid-cycle, i.e. what the next rising edge will see.
    initial begin
        cyc = 0; prev_hold = 0; prev_data = 0;
        done_cnt = 0; valid_cnt = 0; stab_err = 0; last_xfer_cyc = 0; done_cyc = 0; busy_at_done = 0;
        forever begin
            @(negedge CLOCK);
            cyc++;
            if (!RESET_N) begin
                prev_hold = 0;
            end else begin
                if (prev_hold && (!tx_if.tx_valid || tx_if.tx_data != prev_data)) stab_err++;
                prev_hold = tx_if.tx_valid && !tx_if.tx_ready;
                prev_data = tx_if.tx_data;
                if (tx_if.tx_valid) valid_cnt++;
                if (tx_if.tx_valid && tx_if.tx_ready) begin
                    obs.push_back(tx_if.tx_data);
                    last_xfer_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    busy_at_done = busy;
                end
            end
        end
    end

    // Sink behaviour: 0 always ready, 1 toggling, 2 random, 3 stalled.
    initial begin
        tx_if.tx_ready = 1'b1;
        forever begin
            @(posedge CLOCK);
            #1;
            case (ready_mode)
                0: tx_if.tx_ready = 1'b1;
                1: tx_if.tx_ready = ~tx_if.tx_ready;
                2: tx_if.tx_ready = 1'($urandom_range(0, 1));
                default: tx_if.tx_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_write(input int a, input int d);
        wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d[7:0];
        tick();
        wr_en = 1'b0;
        ref_mem[a] = d[7:0];
    endtask

    task automatic clear_mon();
        obs.delete(); done_cnt = 0; valid_cnt = 0; stab_err = 0;
    endtask

    task automatic pulse_start(input int len, input bit rep);
        msg_len = len[4:0]; repeat_mode = rep; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget; n++) begin
            if (done_cnt > 0) break;
            tick();
        end
        tick();
    endtask

    // Expected stream: n_total bytes cycling through the first min(len, 16) entries.
    function automatic void build_exp(input int len, input int n_total);
        int eff;
        eff = (len > 16) ? 16 : len;
        exp_q.delete();
        for (int i = 0; i < n_total; i++) exp_q.push_back(ref_mem[i % eff]);
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (3) tick();
        vectors++; if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_tx_valid got %0d want 0", tx_if.tx_valid); end
        vectors++; if (tx_if.tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_tx_data got %0h want 0", tx_if.tx_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0d want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %0d want 0", done); end
        vectors++; if (aborted !== 1'b0) begin miscompares++; $display("FAIL rst_aborted got %0d want 0", aborted); end
        vectors++; if (cur_idx !== 4'd0) begin miscompares++; $display("FAIL rst_cur_idx got %0d want 0", cur_idx); end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy got %0d want 0", busy); end
    endtask

    task automatic test_init_content();
        ready_mode = 0;
        tick();
        clear_mon();
        msg_len = 5'd3; repeat_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        vectors++; if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL lat_fetch_valid got %0d want 0", tx_if.tx_valid); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL lat_busy got %0d want 1", busy); end
        tick();
        vectors++; if (tx_if.tx_valid !== 1'b1) begin miscompares++; $display("FAIL lat_send_valid got %0d want 1", tx_if.tx_valid); end
        vectors++; if (cur_idx !== 4'd0) begin miscompares++; $display("FAIL lat_cur_idx got %0d want 0", cur_idx); end
        wait_done(100);
        build_exp(3, 3);
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL init_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++; if (obs[i] !== exp_q[i]) begin miscompares++; $display("FAIL init_byte[%0d] got %0h want %0h", i, obs[i], exp_q[i]); end
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL init_done_cnt got %0d want 1", done_cnt); end
        vectors++; if (done_cyc - last_xfer_cyc != 1) begin miscompares++; $display("FAIL init_done_gap got %0d want 1", done_cyc - last_xfer_cyc); end
        vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL init_busy_at_done got %0d want 0", busy_at_done); end
        vectors++; if (aborted !== 1'b0) begin miscompares++; $display("FAIL init_aborted got %0d want 0", aborted); end
    endtask

    task automatic test_handshake_toggle();
        do_write(0, 8'h48); do_write(1, 8'h49); do_write(2, 8'h0A);
        ready_mode = 1;
        clear_mon();
        pulse_start(3, 1'b0);
        wait_done(100);
        ready_mode = 0;
        build_exp(3, 3);
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL tog_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++; if (obs[i] !== exp_q[i]) begin miscompares++; $display("FAIL tog_byte[%0d] got %0h want %0h", i, obs[i], exp_q[i]); end
        end
        vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL tog_stable got %0d violations want 0", stab_err); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL tog_done_cnt got %0d want 1", done_cnt); end
        vectors++; if (done_cyc - last_xfer_cyc != 1) begin miscompares++; $display("FAIL tog_done_gap got %0d want 1", done_cyc - last_xfer_cyc); end
    endtask

    task automatic test_repeat_abort();
        do_write(0, 8'h41); do_write(1, 8'h42);
        ready_mode = 0;
        tick();
        clear_mon();
        pulse_start(2, 1'b1);
        for (int n = 0; n < 100; n++) begin
            if (obs.size() >= 5) break;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(100);
        build_exp(2, 6);
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL abort_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++; if (obs[i] !== exp_q[i]) begin miscompares++; $display("FAIL abort_byte[%0d] got %0h want %0h", i, obs[i], exp_q[i]); end
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL abort_done_cnt got %0d want 1", done_cnt); end
        vectors++; if (aborted !== 1'b1) begin miscompares++; $display("FAIL abort_flag got %0d want 1", aborted); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %0d want 0", busy); end
        // Abort while idle must not start or disturb anything.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_abort_busy got %0d want 0", busy); end
    endtask

    task automatic test_len_bounds();
        clear_mon();
        pulse_start(0, 1'b0);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL zero_done got %0d want 1", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL zero_busy got %0d want 0", busy); end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL zero_done_width got %0d want 0", done); end
        repeat (4) tick();
        vectors++; if (valid_cnt != 0) begin miscompares++; $display("FAIL zero_valid got %0d cycles want 0", valid_cnt); end
        for (int a = 0; a < 16; a++) do_write(a, int'($urandom_range(0, 255)));
        ready_mode = 2;
        clear_mon();
        pulse_start(31, 1'b0);
        wait_done(400);
        ready_mode = 0;
        build_exp(31, 16);
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL clamp_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++; if (obs[i] !== exp_q[i]) begin miscompares++; $display("FAIL clamp_byte[%0d] got %0h want %0h", i, obs[i], exp_q[i]); end
        end
        vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL clamp_stable got %0d violations want 0", stab_err); end
    endtask

    task automatic test_busy_ignore();
        for (int a = 0; a < 4; a++) do_write(a, int'($urandom_range(0, 255)));
        ready_mode = 0;
        tick();
        clear_mon();
        pulse_start(4, 1'b0);
        // Model buffer is deliberately left untouched: both requests must be dropped.
        wr_en = 1'b1; wr_addr = 4'd1; wr_data = ~ref_mem[1];
        msg_len = 5'd2; start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        wait_done(100);
        build_exp(4, 4);
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL busy_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++; if (obs[i] !== exp_q[i]) begin miscompares++; $display("FAIL busy_byte[%0d] got %0h want %0h", i, obs[i], exp_q[i]); end
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL busy_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        for (int a = 0; a < 4; a++) do_write(a, int'($urandom_range(0, 255)));
        ready_mode = 3;
        tick(); tick();
        clear_mon();
        pulse_start(4, 1'b0);
        tick();
        vectors++; if (tx_if.tx_valid !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %0d want 1", tx_if.tx_valid); end
        RESET_N = 1'b0;
        #1;
        vectors++; if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %0d want 0", tx_if.tx_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy got %0d want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mid_done got %0d want 0", done); end
        vectors++; if (cur_idx !== 4'd0) begin miscompares++; $display("FAIL mid_cur_idx got %0d want 0", cur_idx); end
        @(negedge CLOCK);
        RESET_N = 1'b1;
        ready_mode = 0;
        tick(); tick();
        clear_mon();
        pulse_start(4, 1'b0);
        wait_done(100);
        build_exp(4, 4);
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL mid_count got %0d want %0d", obs.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            vectors++; if (obs[i] !== exp_q[i]) begin miscompares++; $display("FAIL mid_byte[%0d] got %0h want %0h", i, obs[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        int len;
        for (int it = 0; it < 5; it++) begin
            len = int'($urandom_range(1, 16));
            for (int a = 0; a < len; a++) do_write(a, int'($urandom_range(0, 255)));
            ready_mode = 2;
            clear_mon();
            pulse_start(len, 1'b0);
            wait_done(400);
            ready_mode = 0;
            build_exp(len, len);
            vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL rnd%0d_count got %0d want %0d", it, obs.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
                vectors++; if (obs[i] !== exp_q[i]) begin miscompares++; $display("FAIL rnd%0d_byte[%0d] got %0h want %0h", it, i, obs[i], exp_q[i]); end
            end
            vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL rnd%0d_stable got %0d violations want 0", it, stab_err); end
            vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL rnd%0d_done_cnt got %0d want 1", it, done_cnt); end
            vectors++; if (done_cyc - last_xfer_cyc != 1) begin miscompares++; $display("FAIL rnd%0d_done_gap got %0d want 1", it, done_cyc - last_xfer_cyc); end
            vectors++; if (aborted !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_aborted got %0d want 0", it, aborted); end
        end
    endtask

    initial begin
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; repeat_mode = 1'b0; start = 1'b0; abort = 1'b0;
        for (int a = 0; a < 16; a++) ref_mem[a] = 8'd139;
        test_reset();
        test_init_content();
        test_handshake_toggle();
        test_repeat_abort();
        test_random();
        test_len_bounds();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
